// File: rtl/serial_subtractor_nbit.sv
// Bit-serial LSB-first subtractor with a single borrow flop.
// Optional signed overflow output: define SUB_SIGNED_OVF_EN.
module serial_subtractor_nbit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CW-1:0]    cnt;
  logic             br_ff;
  logic             x, y;
  logic             bit_d, bit_br;
  logic             last;
  logic             accept;

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb, b_msb;
`endif

  // One full-subtractor slice on the current LSBs
  always_comb begin
    x      = a_sr[0];
    y      = b_sr[0];
    bit_d  = x ^ y ^ br_ff;
    bit_br = (~x & y) | (~(x ^ y) & br_ff);
    last   = (cnt == LAST);
    accept = (state == S_IDLE) && start;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand shifters, bit counter, borrow flop and held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      cnt    <= '0;
      br_ff  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      d_sr   <= '0;
      cnt    <= '0;
      br_ff  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
`endif
    end else if (state == S_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      d_sr  <= {bit_d, d_sr[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      br_ff <= bit_br;
      if (last) begin
        diff   <= {bit_d, d_sr[WIDTH-1:1]};
        borrow <= bit_br;
`ifdef SUB_SIGNED_OVF_EN
        ovf    <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed bench for serial_subtractor_nbit (WIDTH=4).
// Covers reset, latency, wrap, ignored restarts and mid-run reset.
module tb_serial_subtractor_nbit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
  logic         ovf_s;

  int npass = 0;
  int ntot  = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_br   = 1'b0;

  serial_subtractor_nbit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf    (ovf_s)
`endif
  );

`ifndef SUB_SIGNED_OVF_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic do_op(input string tag,
                       input logic [W-1:0] ta,
                       input logic [W-1:0] tb,
                       input logic [W-1:0] ed,
                       input logic eb,
                       input logic eo,
                       input bit rep);
    int n;
    int extra;
    bit seen;
    n = 0;
    seen = 0;
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && n < 20) begin
      if (n == 1) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_hold_d"}, diff, last_diff);
        chk({tag, "_hold_b"}, borrow, last_br);
        if (rep) begin
          a = 4'd1;
          b = 4'd7;
          start = 1'b1;
        end
      end
      if (n == 2) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
`ifdef SUB_SIGNED_OVF_EN
    chk({tag, "_ovf"}, ovf_s, eo);
`endif
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    if (rep) begin
      extra = 0;
      for (int i = 0; i < W + 3; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({tag, "_nodup"}, extra, 0);
      chk({tag, "_keep"}, diff, ed);
    end
    last_diff = ed;
    last_br = eb;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a = 4'd9;
    b = 4'd5;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", ovf_s, 0);
    @(posedge clk); #1;
    chk("rst_hold", busy, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("t2", 4'd9, 4'd5, 4'b0100, 1'b0, 1'b1, 0);
    do_op("t3", 4'd3, 4'd5, 4'b1110, 1'b1, 1'b0, 0);
    do_op("t4", 4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1, 0);
    do_op("t5a", 4'd6, 4'd2, 4'd4, 1'b0, 1'b0, 1);
    do_op("t5b", 4'hA, 4'hA, 4'd0, 1'b0, 1'b0, 0);
    do_op("t6p", 4'd3, 4'd5, 4'b1110, 1'b1, 1'b0, 0);

    a = 4'd9;
    b = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_diff", diff, 0);
    chk("t6_borrow", borrow, 0);
    chk("t6_ovf", ovf_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_diff = '0;
    last_br = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (busy || done) chk("t6_resume", {busy, done}, 0);
    end
    chk("t6_still_idle", busy, 0);
    do_op("t6", 4'd0, 4'd1, 4'b1111, 1'b1, 1'b0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
